// File: rtl/ripple_carry_adder_pkg.sv
// Shared constants and bit-level full-adder equations for the ripple-carry adder.
package ripple_carry_adder_pkg;

    localparam int unsigned RCA_DEFAULT_N = 32'd4;

    function automatic logic fa_sum(input logic a, input logic b, input logic cin);
        return a ^ b ^ cin;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic cin);
        return (a & b) | (cin & (a ^ b));
    endfunction

endpackage

// File: rtl/ripple_carry_adder_fa.sv
// Purely combinational 1-bit full adder, one stage of the ripple chain.
module full_adder
    import ripple_carry_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = fa_sum(a, b, cin);
    assign cout = fa_carry(a, b, cin);

endmodule

// File: rtl/ripple_carry_adder.sv
// N-bit ripple-carry adder with a registered {Cout,Sum} result and a valid flag
// travelling alongside the data (one-cycle arithmetic stage, no backpressure).
module ripple_carry_adder
    import ripple_carry_adder_pkg::*;
#(
    parameter int unsigned N = RCA_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    input  logic         in_valid,
    output logic [N-1:0] Sum,
    output logic         Cout,
    output logic         out_valid
);

    logic [N:0]   carry_s;
    logic [N-1:0] sum_s;
    logic [N-1:0] sum_d;
    logic [N-1:0] sum_q;
    logic         cout_d;
    logic         cout_q;
    logic         valid_d;
    logic         valid_q;

    assign carry_s[0] = Cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        full_adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (carry_s[i]),
            .s    (sum_s[i]),
            .cout (carry_s[i+1])
        );
    end

    // Next-state: load a fresh result only when qualified, otherwise hold so idle X/Z never propagates.
    always_comb begin
        sum_d   = sum_q;
        cout_d  = cout_q;
        valid_d = 1'b0;
        if (in_valid) begin
            sum_d   = sum_s;
            cout_d  = carry_s[N];
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
    end

    // Output register; reset wins over a simultaneous valid input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= {N{1'b0}};
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
        end
    end

    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder at N=4 (directed + exhaustive), N=1 and N=16 (random).
module tb_ripple_carry_adder;

    logic clk;
    logic rst;

    logic [3:0]  a4, b4, sum4;
    logic        cin4, v4, cout4, ov4;
    logic [0:0]  a1, b1, sum1;
    logic        cin1, v1, cout1, ov1;
    logic [15:0] a16, b16, sum16;
    logic        cin16, v16, cout16, ov16;

    int total;
    int bad;

    ripple_carry_adder #(4) dut4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .Cin(cin4), .in_valid(v4),
        .Sum(sum4), .Cout(cout4), .out_valid(ov4)
    );

    ripple_carry_adder #(1) dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(cin1), .in_valid(v1),
        .Sum(sum1), .Cout(cout1), .out_valid(ov1)
    );

    ripple_carry_adder #(16) dut16 (
        .clk(clk), .rst(rst), .A(a16), .B(b16), .Cin(cin16), .in_valid(v16),
        .Sum(sum16), .Cout(cout16), .out_valid(ov16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact sum as plain integer arithmetic, packed as {valid,Cout,Sum}.
    function automatic logic [5:0] ref4(input int a, input int b, input int c);
        int r;
        r = a + b + c;
        return {1'b1, 5'(r)};
    endfunction

    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic c);
        a4 = a; b4 = b; cin4 = c; v4 = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; v4 = 1'b1; a4 = 4'b1111; b4 = 4'b1111; cin4 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            total++;
            if ({ov4, cout4, sum4} !== 6'b000000) begin
                bad++;
                $display("FAIL reset cyc%0d: got {v,c,s}=%b want 000000", k, {ov4, cout4, sum4});
            end
        end
        // Reset still asserted for the result launched in this cycle: discarded.
        a4 = 4'b0001; b4 = 4'b0010; cin4 = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({ov4, cout4, sum4} !== 6'b000000) begin
            bad++;
            $display("FAIL reset_priority: got %b want 000000", {ov4, cout4, sum4});
        end
        rst = 1'b0;
        v4 = 1'b1; a4 = 4'b0110; b4 = 4'b0011; cin4 = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({ov4, cout4, sum4} !== 6'b101010) begin
            bad++;
            $display("FAIL first_after_reset: got %b want 101010", {ov4, cout4, sum4});
        end
    endtask

    task automatic test_directed();
        logic [4:0] av [4];
        logic [4:0] bv [4];
        logic       cv [4];
        logic [5:0] want [4];
        av[0] = 5'd1;  bv[0] = 5'd2; cv[0] = 1'b0; want[0] = 6'b100011;
        av[1] = 5'd5;  bv[1] = 5'd3; cv[1] = 1'b0; want[1] = 6'b101000;
        av[2] = 5'd15; bv[2] = 5'd1; cv[2] = 1'b0; want[2] = 6'b110000;
        av[3] = 5'd15; bv[3] = 5'd15; cv[3] = 1'b1; want[3] = 6'b111111;
        for (int k = 0; k < 4; k++) begin
            drive4(av[k][3:0], bv[k][3:0], cv[k]);
            total++;
            if ({ov4, cout4, sum4} !== want[k]) begin
                bad++;
                $display("FAIL directed%0d: got %b want %b", k, {ov4, cout4, sum4}, want[k]);
            end
        end
    endtask

    task automatic test_hold();
        logic [5:0] held;
        drive4(4'b1010, 4'b0111, 1'b0);
        held = ref4(10, 7, 0);
        total++;
        if ({ov4, cout4, sum4} !== held) begin
            bad++;
            $display("FAIL hold_setup: got %b want %b", {ov4, cout4, sum4}, held);
        end
        v4 = 1'b0; a4 = 4'b0000; b4 = 4'b0000; cin4 = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({ov4, cout4, sum4} !== {1'b0, held[4:0]}) begin
            bad++;
            $display("FAIL hold_idle: got %b want %b", {ov4, cout4, sum4}, {1'b0, held[4:0]});
        end
        a4 = 4'bxxxx; b4 = 4'bzzzz; cin4 = 1'bx;
        @(posedge clk);
        #1;
        total++;
        if ({ov4, cout4, sum4} !== {1'b0, held[4:0]}) begin
            bad++;
            $display("FAIL hold_xz: got %b want %b", {ov4, cout4, sum4}, {1'b0, held[4:0]});
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] prev;
        int a, b, c;
        prev = {ov4, cout4, sum4};
        for (int k = 0; k < 4; k++) begin
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            c = int'($urandom_range(0, 1));
            a4 = 4'(a); b4 = 4'(b); cin4 = 1'(c); v4 = 1'b1;
            #1;
            total++;
            if ({cout4, sum4} !== prev[4:0]) begin
                bad++;
                $display("FAIL b2b_latency%0d: got %b want %b", k, {cout4, sum4}, prev[4:0]);
            end
            @(posedge clk);
            #1;
            prev = ref4(a, b, c);
            total++;
            if ({ov4, cout4, sum4} !== prev) begin
                bad++;
                $display("FAIL b2b%0d: got %b want %b", k, {ov4, cout4, sum4}, prev);
            end
        end
    endtask

    task automatic test_exhaustive4();
        logic [5:0] want;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    drive4(4'(a), 4'(b), 1'(c));
                    want = ref4(a, b, c);
                    total++;
                    if ({ov4, cout4, sum4} !== want) begin
                        bad++;
                        $display("FAIL exh4 a=%0d b=%0d c=%0d: got %b want %b", a, b, c, {ov4, cout4, sum4}, want);
                    end
                end
            end
        end
        v4 = 1'b0;
    endtask

    task automatic test_width1();
        int a, b, c, r;
        for (int k = 0; k < 24; k++) begin
            a = int'($urandom_range(0, 1));
            b = int'($urandom_range(0, 1));
            c = int'($urandom_range(0, 1));
            a1 = 1'(a); b1 = 1'(b); cin1 = 1'(c); v1 = 1'b1;
            @(posedge clk);
            #1;
            r = a + b + c;
            total++;
            if ({ov1, cout1, sum1} !== {1'b1, 2'(r)}) begin
                bad++;
                $display("FAIL w1 a=%0d b=%0d c=%0d: got %b want %b", a, b, c, {ov1, cout1, sum1}, {1'b1, 2'(r)});
            end
        end
        v1 = 1'b0;
    endtask

    task automatic test_width16();
        int a, b, c, r;
        for (int k = 0; k < 200; k++) begin
            a = int'($urandom_range(0, 65535));
            b = int'($urandom_range(0, 65535));
            c = int'($urandom_range(0, 1));
            if (k == 0) begin
                a = 65535; b = 65535; c = 1;
            end else if (k == 1) begin
                a = 65535; b = 0; c = 1;
            end else begin
                a = a;
            end
            a16 = 16'(a); b16 = 16'(b); cin16 = 1'(c); v16 = 1'b1;
            @(posedge clk);
            #1;
            r = a + b + c;
            total++;
            if ({ov16, cout16, sum16} !== {1'b1, 17'(r)}) begin
                bad++;
                $display("FAIL w16 a=%0d b=%0d c=%0d: got %h want %h", a, b, c, {ov16, cout16, sum16}, {1'b1, 17'(r)});
            end
        end
        v16 = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        a4 = 4'b0000; b4 = 4'b0000; cin4 = 1'b0; v4 = 1'b0;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; v1 = 1'b0;
        a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0; v16 = 1'b0;
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_exhaustive4();
        test_width1();
        test_width16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
